slot_game_ctrl: RTL and testbench
=================================

Name: slot_game_ctrl

Overview:
Top-level game sequencer for the DE1 slot machine; the initiator side of the dice handshake. It drives the 2-bit game state consumed by prng_dice, waits for its done/win response, and manages the credit balance. Spin and coin inputs come from raw push-buttons; the outputs feed the display and LED logic.

Parameters:
START_CREDITS, 10, credit balance after reset
BET, 1, credits deducted per accepted spin
PAYOUT, 50, credits added on a win
MAX_CREDITS, 999, saturation ceiling for the balance
RESULT_CYCLES, 100_000_000, RESULT hold time in clocks (2 s at 50 MHz)
RUN_TIMEOUT, 200_000_000, maximum number of clocks to wait for done_i

Ports:
clk_i  in  1  system clock, 50 MHz; the only clock
rst_i  in  1  reset, synchronous, active-high
spin_btn_i  in  1  raw spin button, active-high, asynchronous to clk_i
coin_btn_i  in  1  raw coin button, active-high, asynchronous to clk_i
done_i  in  1  dice-run-complete flag from the dice block
win_i  in  1  five-of-a-kind flag from the dice block; valid one clock after done_i rises
state_o  out  2  game state to the dice block: 00 IDLE, 01 ARM, 10 RUN, 11 RESULT
credits_o  out  10  current credit balance
win_lamp_o  out  1  high for the whole RESULT state when the spin won
timeout_o  out  1  one-clock pulse when RUN is abandoned on timeout
spin_rej_o  out  1  one-clock pulse when a spin is refused for insufficient credits

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge): FSM goes to IDLE. state_o=00, credits_o=START_CREDITS, win_lamp_o=0, timeout_o=0, spin_rej_o=0. Synchronizers, edge detectors and all counters clear. Reset in any state, including RUN, aborts the spin with no refund.
- Inputs: each button passes through a 2-FF synchronizer followed by a rising-edge detector, giving a one-clock pulse. Press-to-pulse latency is 3 clocks. No debounce; debouncing is done upstream.
- Internal FSM states: IDLE, ARM, RUN, SETTLE, RESULT. SETTLE drives state_o=10, the same code as RUN.
- IDLE, spin pulse, credits >= BET: deduct BET and go to ARM.
- IDLE, spin pulse, credits < BET: pulse spin_rej_o and stay in IDLE.
- ARM: lasts exactly 1 clock, then RUN. This guarantees the dice block sees a non-RUN state and clears its run counter.
- RUN: timer counts up from 0.
  - done_i=1: go to SETTLE.
  - Otherwise, timer reaches RUN_TIMEOUT-1: refund BET (saturating), pulse timeout_o, go to IDLE.
  - If done_i and timeout occur in the same cycle, done_i wins.
- SETTLE: lasts 1 clock. At its end, latch win_i into the win flag, add PAYOUT if it is 1, and go to RESULT. A win therefore credits exactly 2 clocks after done_i is first seen.
- RESULT: win_lamp_o equals the latched win flag. A hold timer runs for RESULT_CYCLES clocks, then the FSM returns to IDLE and win_lamp_o returns to 0. Spin pulses in RESULT are ignored, not queued.
- Coin pulse: adds 1 credit in any state.
- Credit arithmetic:
  - All additions saturate at MAX_CREDITS; the balance never exceeds it.
  - A coin arriving in the same cycle as a payout or refund applies both, then saturates once.
  - A coin arriving in the same cycle as an IDLE spin is computed as credits + 1 − BET. The credits >= BET check uses the pre-coin value.
  - Subtraction only happens when credits >= BET, so the balance never wraps.
- Timer widths: the RUN and RESULT timers are sized with $clog2 of their parameter, rounded up to at least 1 bit. Counting is unsigned.
- Single-cycle pulses never overlap one another.

Decomposition:
- Shared package slot_pkg:
  - state codes ST_IDLE=2'b00, ST_ARM=2'b01, ST_RUN=2'b10, ST_RESULT=2'b11; the dice block also uses ST_RUN.
  - CREDIT_W=10.
  - An internal FSM enum, with SETTLE encoded apart from the 2-bit output codes.
- One natural sub-module, btn_sync_edge: 2-FF synchronizer plus rising-edge pulse. It is instantiated twice, once per button.

Test Plan:
All scenarios use RESULT_CYCLES=8 and RUN_TIMEOUT=20, with a dice-block model whose done latency is programmable.
1. Reset, then spin with done_i at RUN clock 5 and win_i=1 the next clock. Required: credits 10→9→59; state_o sequence 01, 10×7, 11×8, 00; win_lamp_o=1 for exactly 8 clocks.
2. Same spin with win_i=0. Required: credits=9 at end, win_lamp_o stays 0.
3. done_i never asserts. Required: after 20 RUN clocks timeout_o pulses once, credits return to 10, state_o=00.
4. Start credits at 0 (START_CREDITS=0) and press spin. Required: spin_rej_o pulses once, state_o stays 00. Then press coin and spin. Required: credits 1→0, state goes to ARM.
5. START_CREDITS=990, win. Required: credits saturate at 999. A coin in the same cycle as the payout also gives 999.
6. Assert rst_i in the middle of RUN. Required: next clock state_o=00, credits=START_CREDITS, all pulses 0. A spin held across reset release is not accepted until a new rising edge.

Source files
------------

// File: rtl/slot_pkg.sv
// -----------------------------------------------------------------------------
// slot_pkg
// Shared definitions for the DE1 slot machine.
//   - ST_* : 2-bit game-state codes driven to the dice block.
//   - CREDIT_W : width of the credit balance.
//   - game_fsm_t : internal sequencer states; SETTLE has its own encoding
//     outside the 2-bit output code space.
//   - sat_credit : clamps a wide credit value to a ceiling.
// -----------------------------------------------------------------------------
package slot_pkg;

    localparam int CREDIT_W = 10;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ARM    = 2'b01;
    localparam logic [1:0] ST_RUN    = 2'b10;
    localparam logic [1:0] ST_RESULT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_ARM    = 3'b001,
        S_RUN    = 3'b010,
        S_RESULT = 3'b011,
        S_SETTLE = 3'b100
    } game_fsm_t;

    // Caller guarantees v is non-negative (no subtraction below zero).
    function automatic logic [CREDIT_W-1:0] sat_credit(input logic [31:0] v,
                                                       input logic [31:0] max_v);
        logic [31:0] r;
        r = (v > max_v) ? max_v : v;
        return CREDIT_W'(r);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// 2-FF synchronizer followed by a registered rising-edge detector.
// A press produces a single-clock pulse_o three clocks after btn_i rises.
// Ports:
//   clk_i   in  system clock
//   rst_i   in  synchronous active-high reset
//   btn_i   in  raw button, asynchronous to clk_i
//   pulse_o out one-clock pulse per rising edge of the synchronized button
// -----------------------------------------------------------------------------
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic       sync1_q, sync2_q, prev_q, pulse_q, armed_q;
    logic [1:0] fill_q;

    // fill_q tracks how far real button samples have propagated since reset.
    // armed_q is only set once a genuine low level has been synchronized, so a
    // button held through reset release never looks like a fresh press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & ~sync2_q);
            pulse_q <= sync2_q & ~prev_q & armed_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/slot_game_ctrl.sv
// -----------------------------------------------------------------------------
// slot_game_ctrl
// Game sequencer for the DE1 slot machine: initiator of the dice handshake
// and keeper of the credit balance.
// Ports:
//   clk_i       in  50 MHz system clock
//   rst_i       in  synchronous active-high reset
//   spin_btn_i  in  raw spin button (asynchronous)
//   coin_btn_i  in  raw coin button (asynchronous)
//   done_i      in  dice run complete
//   win_i       in  five-of-a-kind, valid one clock after done_i rises
//   state_o     out game state to dice block (00 IDLE,01 ARM,10 RUN,11 RESULT)
//   credits_o   out credit balance
//   win_lamp_o  out high throughout RESULT when the spin won
//   timeout_o   out one-clock pulse when RUN is abandoned
//   spin_rej_o  out one-clock pulse when a spin is refused for lack of credit
// -----------------------------------------------------------------------------
module slot_game_ctrl
    import slot_pkg::*;
#(
    parameter int unsigned START_CREDITS = 10,
    parameter int unsigned BET           = 1,
    parameter int unsigned PAYOUT        = 50,
    parameter int unsigned MAX_CREDITS   = 999,
    parameter int unsigned RESULT_CYCLES = 100_000_000,
    parameter int unsigned RUN_TIMEOUT   = 200_000_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                spin_btn_i,
    input  logic                coin_btn_i,
    input  logic                done_i,
    input  logic                win_i,
    output logic [1:0]          state_o,
    output logic [CREDIT_W-1:0] credits_o,
    output logic                win_lamp_o,
    output logic                timeout_o,
    output logic                spin_rej_o
);

    localparam int RUN_W  = (RUN_TIMEOUT   > 1) ? $clog2(RUN_TIMEOUT)   : 1;
    localparam int HOLD_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_CYCLES - 1);

    logic spin_pulse, coin_pulse;

    btn_sync_edge u_spin (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (spin_btn_i),
        .pulse_o (spin_pulse)
    );

    btn_sync_edge u_coin (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (coin_btn_i),
        .pulse_o (coin_pulse)
    );

    game_fsm_t            state_q, state_d;
    logic [CREDIT_W-1:0]  credits_q, credits_d;
    logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 win_q, win_d;
    logic                 timeout_q, timeout_d;
    logic                 spin_rej_q, spin_rej_d;
    logic [31:0]          add_v, sub_v;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            credits_q  <= CREDIT_W'(START_CREDITS);
            run_cnt_q  <= '0;
            hold_cnt_q <= '0;
            win_q      <= 1'b0;
            timeout_q  <= 1'b0;
            spin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            run_cnt_q  <= run_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            win_q      <= win_d;
            timeout_q  <= timeout_d;
            spin_rej_q <= spin_rej_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        hold_cnt_d = hold_cnt_q;
        win_d      = win_q;
        timeout_d  = 1'b0;
        spin_rej_d = 1'b0;
        add_v      = '0;
        sub_v      = '0;

        case (state_q)
            S_IDLE: begin
                // Affordability is judged on the balance before any same-cycle coin.
                if (spin_pulse) begin
                    if (32'(credits_q) >= BET) begin
                        sub_v   = BET;
                        state_d = S_ARM;
                    end else begin
                        spin_rej_d = 1'b1;
                    end
                end
            end
            S_ARM: begin
                // One non-RUN clock lets the dice block clear its run counter.
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (done_i) begin
                    state_d = S_SETTLE;
                end else if (run_cnt_q == RUN_LAST) begin
                    add_v     = BET;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                // win_i becomes valid one clock after done_i, i.e. here.
                win_d      = win_i;
                add_v      = win_i ? PAYOUT : 32'd0;
                hold_cnt_d = '0;
                state_d    = S_RESULT;
            end
            S_RESULT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    win_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Coin, payout/refund and bet combine first, then saturate once.
        credits_d = sat_credit(32'(credits_q) + 32'(coin_pulse) + add_v - sub_v,
                               MAX_CREDITS);
    end

    always_comb begin
        case (state_q)
            S_IDLE:   state_o = ST_IDLE;
            S_ARM:    state_o = ST_ARM;
            S_RUN:    state_o = ST_RUN;
            S_SETTLE: state_o = ST_RUN;
            S_RESULT: state_o = ST_RESULT;
            default:  state_o = ST_IDLE;
        endcase
    end

    assign credits_o  = credits_q;
    assign win_lamp_o = (state_q == S_RESULT) & win_q;
    assign timeout_o  = timeout_q;
    assign spin_rej_o = spin_rej_q;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slot_game_ctrl
// Directed bench for slot_game_ctrl. Three instances with different starting
// balances share all inputs; each scenario resets them and watches the one
// selected by sel. A small dice model raises done_i at a chosen RUN clock and
// win_i one clock later.
// -----------------------------------------------------------------------------
module tb_slot_game_ctrl;

    logic clk, rst, spin, coin, done, win;
    logic [1:0] st_a, st_z, st_h, st_m;
    logic [9:0] cr_a, cr_z, cr_h, cr_m;
    logic lamp_a, lamp_z, lamp_h, lamp_m;
    logic to_a, to_z, to_h, to_m;
    logic rej_a, rej_z, rej_h, rej_m;
    int   sel;

    int passed = 0;
    int total  = 0;

    int run_obs;
    bit done_sent;
    logic [1:0] ost [32];
    logic [9:0] ocr [32];
    logic       olamp [32];
    logic       oto [32];

    slot_game_ctrl #(.START_CREDITS(10), .RESULT_CYCLES(8), .RUN_TIMEOUT(20)) u_a (
        .clk_i(clk), .rst_i(rst), .spin_btn_i(spin), .coin_btn_i(coin),
        .done_i(done), .win_i(win), .state_o(st_a), .credits_o(cr_a),
        .win_lamp_o(lamp_a), .timeout_o(to_a), .spin_rej_o(rej_a));

    slot_game_ctrl #(.START_CREDITS(0), .RESULT_CYCLES(8), .RUN_TIMEOUT(20)) u_z (
        .clk_i(clk), .rst_i(rst), .spin_btn_i(spin), .coin_btn_i(coin),
        .done_i(done), .win_i(win), .state_o(st_z), .credits_o(cr_z),
        .win_lamp_o(lamp_z), .timeout_o(to_z), .spin_rej_o(rej_z));

    slot_game_ctrl #(.START_CREDITS(990), .RESULT_CYCLES(8), .RUN_TIMEOUT(20)) u_h (
        .clk_i(clk), .rst_i(rst), .spin_btn_i(spin), .coin_btn_i(coin),
        .done_i(done), .win_i(win), .state_o(st_h), .credits_o(cr_h),
        .win_lamp_o(lamp_h), .timeout_o(to_h), .spin_rej_o(rej_h));

    always_comb begin
        st_m = st_a; cr_m = cr_a; lamp_m = lamp_a; to_m = to_a; rej_m = rej_a;
        case (sel)
            1: begin st_m = st_z; cr_m = cr_z; lamp_m = lamp_z; to_m = to_z; rej_m = rej_z; end
            2: begin st_m = st_h; cr_m = cr_h; lamp_m = lamp_h; to_m = to_h; rej_m = rej_h; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1; spin = 1'b0; coin = 1'b0; done = 1'b0; win = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
        run_obs = 0; done_sent = 1'b0;
    endtask

    // Dice model: done_i at RUN clock done_at (negative = never), win_i next clock.
    task automatic dice_step(input int done_at, input bit wv);
        if (win) win = 1'b0;
        if (done) begin
            done = 1'b0;
            win  = wv;
        end
        if (st_m == 2'b10 && !done_sent) begin
            if (run_obs == done_at) begin
                done = 1'b1;
                done_sent = 1'b1;
            end
            run_obs++;
        end
    endtask

    // Steps n clocks from ARM, recording outputs; raises coin after sample coin_at.
    task automatic run_spin(input int done_at, input bit wv, input int coin_at, input int n);
        run_obs = 0; done_sent = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            ost[i] = st_m; ocr[i] = cr_m; olamp[i] = lamp_m; oto[i] = to_m;
            if (coin_at >= 0 && i == coin_at) coin = 1'b1;
            if (coin_at >= 0 && i == coin_at + 2) coin = 1'b0;
            dice_step(done_at, wv);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        reset_all();
        total++; if (st_a !== 2'b00) $display("FAIL reset_state got=%b exp=00", st_a); else passed++;
        total++; if (cr_a !== 10'd10) $display("FAIL reset_credits_a got=%0d exp=10", cr_a); else passed++;
        total++; if (cr_z !== 10'd0) $display("FAIL reset_credits_z got=%0d exp=0", cr_z); else passed++;
        total++; if (cr_h !== 10'd990) $display("FAIL reset_credits_h got=%0d exp=990", cr_h); else passed++;
        total++; if ({lamp_a, to_a, rej_a} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {lamp_a, to_a, rej_a}); else passed++;
    endtask

    task automatic test_spin_win();
        logic [1:0] es;
        logic [9:0] ec;
        sel = 0;
        reset_all();
        spin = 1'b1; repeat (4) tick(); spin = 1'b0;
        total++; if (st_m !== 2'b01) $display("FAIL win_arm_state got=%b exp=01", st_m); else passed++;
        total++; if (cr_m !== 10'd9) $display("FAIL win_bet_credits got=%0d exp=9", cr_m); else passed++;
        run_spin(5, 1'b1, -1, 16);
        for (int i = 0; i < 16; i++) begin
            es = (i < 7) ? 2'b10 : (i < 15) ? 2'b11 : 2'b00;
            ec = (i < 7) ? 10'd9 : 10'd59;
            total++; if (ost[i] !== es) $display("FAIL win_state[%0d] got=%b exp=%b", i, ost[i], es); else passed++;
            total++; if (olamp[i] !== (i >= 7 && i < 15)) $display("FAIL win_lamp[%0d] got=%b", i, olamp[i]); else passed++;
            total++; if (ocr[i] !== ec) $display("FAIL win_credits[%0d] got=%0d exp=%0d", i, ocr[i], ec); else passed++;
        end
    endtask

    task automatic test_spin_lose();
        int nl;
        sel = 0;
        reset_all();
        spin = 1'b1; repeat (4) tick(); spin = 1'b0;
        run_spin(5, 1'b0, -1, 16);
        nl = 0;
        for (int i = 0; i < 16; i++) if (olamp[i]) nl++;
        total++; if (nl != 0) $display("FAIL lose_lamp got=%0d high clocks exp=0", nl); else passed++;
        total++; if (ocr[15] !== 10'd9) $display("FAIL lose_credits got=%0d exp=9", ocr[15]); else passed++;
        total++; if (ost[7] !== 2'b11) $display("FAIL lose_result_state got=%b exp=11", ost[7]); else passed++;
        total++; if (ost[15] !== 2'b00) $display("FAIL lose_end_state got=%b exp=00", ost[15]); else passed++;
    endtask

    task automatic test_timeout();
        int nt;
        sel = 0;
        reset_all();
        spin = 1'b1; repeat (4) tick(); spin = 1'b0;
        run_spin(-1, 1'b0, -1, 22);
        nt = 0;
        for (int i = 0; i < 22; i++) if (oto[i]) nt++;
        total++; if (ost[19] !== 2'b10) $display("FAIL to_last_run_state got=%b exp=10", ost[19]); else passed++;
        total++; if (ocr[19] !== 10'd9) $display("FAIL to_run_credits got=%0d exp=9", ocr[19]); else passed++;
        total++; if (ost[20] !== 2'b00) $display("FAIL to_idle_state got=%b exp=00", ost[20]); else passed++;
        total++; if (ocr[20] !== 10'd10) $display("FAIL to_refund got=%0d exp=10", ocr[20]); else passed++;
        total++; if (oto[20] !== 1'b1) $display("FAIL to_pulse_time got=%b exp=1", oto[20]); else passed++;
        total++; if (nt != 1) $display("FAIL to_pulse_count got=%0d exp=1", nt); else passed++;
    endtask

    task automatic test_reject();
        sel = 1;
        reset_all();
        spin = 1'b1; repeat (4) tick();
        total++; if (rej_m !== 1'b1) $display("FAIL rej_pulse got=%b exp=1", rej_m); else passed++;
        total++; if (st_m !== 2'b00) $display("FAIL rej_state got=%b exp=00", st_m); else passed++;
        total++; if (cr_m !== 10'd0) $display("FAIL rej_credits got=%0d exp=0", cr_m); else passed++;
        tick();
        total++; if (rej_m !== 1'b0) $display("FAIL rej_single got=%b exp=0", rej_m); else passed++;
        spin = 1'b0;
        coin = 1'b1; repeat (4) tick(); coin = 1'b0;
        total++; if (cr_m !== 10'd1) $display("FAIL rej_coin got=%0d exp=1", cr_m); else passed++;
        repeat (3) tick();
        spin = 1'b1; repeat (4) tick(); spin = 1'b0;
        total++; if (cr_m !== 10'd0) $display("FAIL rej_then_bet got=%0d exp=0", cr_m); else passed++;
        total++; if (st_m !== 2'b01) $display("FAIL rej_then_arm got=%b exp=01", st_m); else passed++;
    endtask

    task automatic test_saturate();
        sel = 2;
        reset_all();
        spin = 1'b1; repeat (4) tick(); spin = 1'b0;
        total++; if (cr_m !== 10'd989) $display("FAIL sat_bet got=%0d exp=989", cr_m); else passed++;
        run_spin(5, 1'b1, -1, 16);
        total++; if (ocr[7] !== 10'd999) $display("FAIL sat_payout got=%0d exp=999", ocr[7]); else passed++;
        total++; if (ost[15] !== 2'b00) $display("FAIL sat_end_state got=%b exp=00", ost[15]); else passed++;
        spin = 1'b1; repeat (4) tick(); spin = 1'b0;
        total++; if (cr_m !== 10'd998) $display("FAIL sat_bet2 got=%0d exp=998", cr_m); else passed++;
        run_spin(5, 1'b1, 3, 16);
        total++; if (ocr[6] !== 10'd998) $display("FAIL sat_pre_payout got=%0d exp=998", ocr[6]); else passed++;
        total++; if (ocr[7] !== 10'd999) $display("FAIL sat_coin_payout got=%0d exp=999", ocr[7]); else passed++;
        coin = 1'b1; repeat (4) tick(); coin = 1'b0;
        total++; if (cr_m !== 10'd999) $display("FAIL sat_coin_idle got=%0d exp=999", cr_m); else passed++;
    endtask

    task automatic test_coin_combos();
        sel = 0;
        reset_all();
        spin = 1'b1; coin = 1'b1; repeat (4) tick(); spin = 1'b0; coin = 1'b0;
        total++; if (st_m !== 2'b01) $display("FAIL combo_arm got=%b exp=01", st_m); else passed++;
        total++; if (cr_m !== 10'd10) $display("FAIL combo_spin_coin got=%0d exp=10", cr_m); else passed++;
        run_spin(5, 1'b1, 3, 16);
        total++; if (ocr[6] !== 10'd10) $display("FAIL combo_settle got=%0d exp=10", ocr[6]); else passed++;
        total++; if (ocr[7] !== 10'd61) $display("FAIL combo_coin_payout got=%0d exp=61", ocr[7]); else passed++;
        total++; if (ost[15] !== 2'b00) $display("FAIL combo_end_state got=%b exp=00", ost[15]); else passed++;
    endtask

    task automatic test_reset_in_run();
        sel = 0;
        reset_all();
        spin = 1'b1; repeat (4) tick();
        repeat (3) tick();
        total++; if (st_m !== 2'b10) $display("FAIL rr_in_run got=%b exp=10", st_m); else passed++;
        rst = 1'b1; tick();
        total++; if (st_m !== 2'b00) $display("FAIL rr_state got=%b exp=00", st_m); else passed++;
        total++; if (cr_m !== 10'd10) $display("FAIL rr_credits got=%0d exp=10", cr_m); else passed++;
        total++; if ({lamp_m, to_m, rej_m} !== 3'b000) $display("FAIL rr_flags got=%b exp=000", {lamp_m, to_m, rej_m}); else passed++;
        rst = 1'b0;
        repeat (8) tick();
        total++; if (st_m !== 2'b00) $display("FAIL rr_held_state got=%b exp=00", st_m); else passed++;
        total++; if (cr_m !== 10'd10) $display("FAIL rr_held_credits got=%0d exp=10", cr_m); else passed++;
        spin = 1'b0; repeat (3) tick();
        spin = 1'b1; repeat (4) tick(); spin = 1'b0;
        total++; if (st_m !== 2'b01) $display("FAIL rr_new_press_state got=%b exp=01", st_m); else passed++;
        total++; if (cr_m !== 10'd9) $display("FAIL rr_new_press_credits got=%0d exp=9", cr_m); else passed++;
    endtask

    initial begin
        sel = 0;
        rst = 1'b1; spin = 1'b0; coin = 1'b0; done = 1'b0; win = 1'b0;
        test_reset();
        test_spin_win();
        test_spin_lose();
        test_timeout();
        test_reject();
        test_saturate();
        test_coin_combos();
        test_reset_in_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
